// File: rtl/calc_pkg.sv
// Shared definitions for the stack calculator: opcodes, error codes, FSM state.
package calc_pkg;

  localparam logic [3:0] OP_PUSH  = 4'd0;
  localparam logic [3:0] OP_POP   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_DIV   = 4'd5;
  localparam logic [3:0] OP_MOD   = 4'd6;
  localparam logic [3:0] OP_DUP   = 4'd7;
  localparam logic [3:0] OP_SWAP  = 4'd8;
  localparam logic [3:0] OP_CLEAR = 4'd9;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_OVF  = 3'd1;
  localparam logic [2:0] ERR_UNF  = 3'd2;
  localparam logic [2:0] ERR_DIVZ = 3'd3;
  localparam logic [2:0] ERR_ILL  = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    DIV_BUSY,
    ERROR
  } state_t;

endpackage

// File: rtl/calc_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// Ports: clk, reset (async active-low), start (load operands), done (high on
// the cycle whose edge completes the last step), dividend, divisor,
// quotient/remainder (final values valid while done=1).
module calc_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNTW = $clog2(WIDTH + 1);

  logic             busy;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH:0]   trial, diff;
  logic             fits;

  // quotient/remainder are the combinational result of the current step, so
  // the last step's result is usable on the same edge that completes it.
  always_comb begin
    trial     = {rem_q, quo_q[WIDTH-1]};
    diff      = trial - {1'b0, dvs_q};
    fits      = ~diff[WIDTH];
    remainder = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quotient  = {quo_q[WIDTH-2:0], fits};
    done      = busy && (cnt == CNTW'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CNTW'(WIDTH);
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (busy) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt   <= cnt - CNTW'(1);
      if (cnt == CNTW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/stack_calc_param.sv
// Parametrised RPN stack calculator with sticky error reporting.
// Ports: clk, reset (async active-low), in (PUSH operand), op (opcode),
// apply (request), ready, tail (top of stack, 0 when empty), count, empty,
// full, valid (0 while an error is latched), err (latched error code).
module stack_calc_param
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic [3:0]                 op,
  input  logic                       apply,
  output logic                       ready,
  output logic [WIDTH-1:0]           tail,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       valid,
  output logic [2:0]                 err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  state_t           state_q, state_n;
  logic [CW-1:0]    count_q, count_n;
  logic [2:0]       err_q, err_n, err_code;
  logic             is_mod_q, is_mod_n;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    a_idx, b_idx;
  logic [WIDTH-1:0] a, b, alu_res;
  logic             wr0_en, wr1_en;
  logic [CW-1:0]    wr0_idx, wr1_idx;
  logic [WIDTH-1:0] wr0_data, wr1_data;

  logic             div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign a_idx = count_q - C_ONE;
  assign b_idx = count_q - C_TWO;
  assign a     = mem[a_idx];
  assign b     = mem[b_idx];

  assign ready = (state_q != DIV_BUSY);
  assign valid = (state_q != ERROR);
  assign err   = err_q;
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == C_FULL);
  assign tail  = (count_q == '0) ? '0 : a;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_MUL:  alu_res = a * b;
      default: alu_res = '0;
    endcase
  end

  calc_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .done      (div_done),
    .dividend  (a),
    .divisor   (b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_n   = state_q;
    count_n   = count_q;
    err_n     = err_q;
    is_mod_n  = is_mod_q;
    err_code  = ERR_NONE;
    wr0_en    = 1'b0;
    wr0_idx   = '0;
    wr0_data  = '0;
    wr1_en    = 1'b0;
    wr1_idx   = '0;
    wr1_data  = '0;
    div_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (apply) begin
          case (op)
            OP_PUSH: begin
              if (full) err_code = ERR_OVF;
              else begin
                wr0_en = 1'b1; wr0_idx = count_q; wr0_data = in;
                count_n = count_q + C_ONE;
              end
            end
            OP_POP: begin
              if (empty) err_code = ERR_UNF;
              else count_n = a_idx;
            end
            OP_ADD, OP_SUB, OP_MUL: begin
              if (count_q < C_TWO) err_code = ERR_UNF;
              else begin
                wr0_en = 1'b1; wr0_idx = b_idx; wr0_data = alu_res;
                count_n = a_idx;
              end
            end
            OP_DIV, OP_MOD: begin
              if (count_q < C_TWO)  err_code = ERR_UNF;
              else if (b == '0)     err_code = ERR_DIVZ;
              else begin
                div_start = 1'b1;
                is_mod_n  = (op == OP_MOD);
                state_n   = DIV_BUSY;
              end
            end
            OP_DUP: begin
              if (empty)     err_code = ERR_UNF;
              else if (full) err_code = ERR_OVF;
              else begin
                wr0_en = 1'b1; wr0_idx = count_q; wr0_data = a;
                count_n = count_q + C_ONE;
              end
            end
            OP_SWAP: begin
              if (count_q < C_TWO) err_code = ERR_UNF;
              else begin
                wr0_en = 1'b1; wr0_idx = a_idx; wr0_data = b;
                wr1_en = 1'b1; wr1_idx = b_idx; wr1_data = a;
              end
            end
            OP_CLEAR: count_n = '0;
            default:  err_code = ERR_ILL;
          endcase
          if (err_code != ERR_NONE) begin
            err_n   = err_code;
            state_n = ERROR;
          end
        end
      end
      DIV_BUSY: begin
        // Operands stay in place while dividing; the result replaces B and A is dropped.
        if (div_done) begin
          wr0_en   = 1'b1;
          wr0_idx  = b_idx;
          wr0_data = is_mod_q ? div_rem : div_quo;
          count_n  = a_idx;
          state_n  = IDLE;
        end
      end
      ERROR: begin
        if (apply && op == OP_CLEAR) begin
          count_n = '0;
          err_n   = ERR_NONE;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      err_q    <= ERR_NONE;
      is_mod_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      err_q    <= err_n;
      is_mod_q <= is_mod_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr0_idx] <= wr0_data;
    if (wr1_en) mem[wr1_idx] <= wr1_data;
  end

endmodule

// File: tb/tb_stack_calc_param.sv
module tb_stack_calc_param;
  import calc_pkg::*;

  localparam int W = 8;
  localparam int D = 5;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] d_in = '0;
  logic [3:0]   op = '0;
  logic         apply = 1'b0;
  logic         ready, empty, full, valid;
  logic [W-1:0] tail;
  logic [$clog2(D+1)-1:0] count;
  logic [2:0]   err;

  stack_calc_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (d_in),
    .op    (op),
    .apply (apply),
    .ready (ready),
    .tail  (tail),
    .count (count),
    .empty (empty),
    .full  (full),
    .valid (valid),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tail;
    int count;
    int err;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   m_stk[$];
  int   m_err = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] o, input int v, output exp_t e);
    int sz, ta, tb_;
    e.lat = 0;
    sz = m_stk.size();
    if (m_err != 0) begin
      if (o == OP_CLEAR) begin m_stk.delete(); m_err = 0; end
    end else begin
      if (sz > 0) ta  = m_stk[sz-1];
      if (sz > 1) tb_ = m_stk[sz-2];
      case (o)
        OP_PUSH: if (sz == D) m_err = 1; else m_stk.push_back(v & MASK);
        OP_POP:  if (sz == 0) m_err = 2; else void'(m_stk.pop_back());
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: begin
          if (sz < 2) m_err = 2;
          else if ((o == OP_DIV || o == OP_MOD) && tb_ == 0) m_err = 3;
          else begin
            void'(m_stk.pop_back());
            void'(m_stk.pop_back());
            case (o)
              OP_ADD:  m_stk.push_back((ta + tb_) & MASK);
              OP_SUB:  m_stk.push_back((ta - tb_) & MASK);
              OP_MUL:  m_stk.push_back((ta * tb_) & MASK);
              OP_DIV:  begin m_stk.push_back(ta / tb_); e.lat = W; end
              default: begin m_stk.push_back(ta % tb_); e.lat = W; end
            endcase
          end
        end
        OP_DUP: begin
          if (sz == 0) m_err = 2;
          else if (sz == D) m_err = 1;
          else m_stk.push_back(ta);
        end
        OP_SWAP: begin
          if (sz < 2) m_err = 2;
          else begin m_stk[sz-1] = tb_; m_stk[sz-2] = ta; end
        end
        OP_CLEAR: m_stk.delete();
        default:  m_err = 4;
      endcase
    end
    e.count = m_stk.size();
    e.tail  = (e.count == 0) ? 0 : m_stk[e.count-1];
    e.err   = m_err;
  endtask

  task automatic compare(input string tag, input exp_t e);
    chk({tag, ".tail"},  tail,  e.tail);
    chk({tag, ".count"}, count, e.count);
    chk({tag, ".err"},   err,   e.err);
    chk({tag, ".valid"}, valid, (e.err == 0) ? 1 : 0);
    chk({tag, ".empty"}, empty, (e.count == 0) ? 1 : 0);
    chk({tag, ".full"},  full,  (e.count == D) ? 1 : 0);
    chk({tag, ".ready"}, ready, 1);
  endtask

  // Called at posedge+1; returns at posedge+1 after the result is visible.
  task automatic step(input string tag, input logic [3:0] o, input int v,
                      input bit wait_div, input bit poke);
    exp_t e;
    int n;
    model(o, v, e);
    sb.push_back(e);
    apply = 1'b1;
    op    = o;
    d_in  = v[W-1:0];
    @(posedge clk); #1;
    if (poke) begin op = OP_PUSH; d_in = 8'd99; end
    else apply = 1'b0;
    e = sb.pop_front();
    if (e.lat > 0) begin
      chk({tag, ".busy"}, ready, 0);
      if (!wait_div) begin apply = 1'b0; return; end
      n = 0;
      while (ready !== 1'b1 && n < 64) begin
        @(posedge clk); #1;
        n++;
      end
      apply = 1'b0;
      chk({tag, ".latency"}, n, e.lat);
    end
    apply = 1'b0;
    compare(tag, e);
  endtask

  initial begin
    exp_t e0;
    e0.tail = 0; e0.count = 0; e0.err = 0; e0.lat = 0;

    #2;
    sb.push_back(e0);
    compare("reset", sb.pop_front());
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 6; i++) step("push_full", OP_PUSH, 4, 1'b0, 1'b0);
    chk("ovf.err", err, 1);
    step("clr1", OP_CLEAR, 0, 1'b0, 1'b0);

    step("p7", OP_PUSH, 7, 1'b0, 1'b0);
    step("p86", OP_PUSH, 86, 1'b0, 1'b0);
    step("div", OP_DIV, 0, 1'b1, 1'b0);
    chk("div.const", tail, 12);
    step("clr2", OP_CLEAR, 0, 1'b0, 1'b0);
    step("p7b", OP_PUSH, 7, 1'b0, 1'b0);
    step("p86b", OP_PUSH, 86, 1'b0, 1'b0);
    step("mod_busy_apply", OP_MOD, 0, 1'b1, 1'b1);
    chk("mod.const", tail, 2);
    step("clr3", OP_CLEAR, 0, 1'b0, 1'b0);

    step("p0", OP_PUSH, 0, 1'b0, 1'b0);
    step("p86c", OP_PUSH, 86, 1'b0, 1'b0);
    step("divz", OP_DIV, 0, 1'b0, 1'b0);
    chk("divz.const", err, 3);
    step("err_push", OP_PUSH, 1, 1'b0, 1'b0);
    step("clr4", OP_CLEAR, 0, 1'b0, 1'b0);

    step("p100", OP_PUSH, 100, 1'b0, 1'b0);
    step("p200", OP_PUSH, 200, 1'b0, 1'b0);
    step("add", OP_ADD, 0, 1'b0, 1'b0);
    chk("add.const", tail, 44);
    step("p3", OP_PUSH, 3, 1'b0, 1'b0);
    step("p2", OP_PUSH, 2, 1'b0, 1'b0);
    step("sub", OP_SUB, 0, 1'b0, 1'b0);
    chk("sub.const", tail, 255);
    step("mul", OP_MUL, 0, 1'b0, 1'b0);
    chk("mul.const", tail, 212);
    step("p9", OP_PUSH, 9, 1'b0, 1'b0);
    step("dup", OP_DUP, 0, 1'b0, 1'b0);
    step("swap_prep", OP_PUSH, 1, 1'b0, 1'b0);
    step("swap", OP_SWAP, 0, 1'b0, 1'b0);
    step("pop", OP_POP, 0, 1'b0, 1'b0);
    step("clr5", OP_CLEAR, 0, 1'b0, 1'b0);

    step("p5", OP_PUSH, 5, 1'b0, 1'b0);
    step("swap_unf", OP_SWAP, 0, 1'b0, 1'b0);
    chk("swap_unf.const", err, 2);
    step("clr6", OP_CLEAR, 0, 1'b0, 1'b0);
    step("pop_unf", OP_POP, 0, 1'b0, 1'b0);
    step("clr7", OP_CLEAR, 0, 1'b0, 1'b0);

    step("ill", 4'd12, 0, 1'b0, 1'b0);
    chk("ill.const", err, 4);
    step("ill_push", OP_PUSH, 9, 1'b0, 1'b0);
    step("clr8", OP_CLEAR, 0, 1'b0, 1'b0);

    step("p3r", OP_PUSH, 3, 1'b0, 1'b0);
    step("p9r", OP_PUSH, 9, 1'b0, 1'b0);
    step("div_abort", OP_DIV, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    m_stk.delete();
    m_err = 0;
    sb.push_back(e0);
    compare("midreset", sb.pop_front());
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    sb.push_back(e0);
    compare("after_abort", sb.pop_front());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
